// File: rtl/sigmoid_share_arbiter_pkg.sv
// Shared types and defaults for the sigmoid sharing block.
// Q3.5 signed inputs, Q0.8 unsigned results, response entry layout.
package act_pkg;

  localparam int X_W            = 8;  // Q3.5 signed
  localparam int Y_W            = 8;  // Q0.8 unsigned
  localparam int N_REQ_DEF      = 4;
  localparam int UNIT_LAT_DEF   = 1;
  localparam int FIFO_DEPTH_DEF = 4;
  // id field is sized for the largest supported requester count (16)
  localparam int ID_W_MAX       = 4;

  typedef struct packed {
    logic [Y_W-1:0]      y;
    logic [ID_W_MAX-1:0] id;
  } rsp_entry_t;

endpackage

// File: rtl/sigmoid_rsp_fifo.sv
// Synchronous first-word-fall-through FIFO with a registered occupancy count.
// Push on a full FIFO is only accepted together with a pop; pop on empty is ignored.
module sigmoid_rsp_fifo #(
  parameter int W     = 12,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push_i,
  input  logic [W-1:0] din_i,
  input  logic         pop_i,
  output logic [W-1:0] dout_o,
  output logic         valid_o,
  output logic [$clog2(DEPTH):0] count_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [DEPTH-1:0][W-1:0] mem_q;
  logic [AW-1:0]           wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]           count_q, count_d;
  logic                    push_eff, pop_eff;

  // qualify push/pop against occupancy and form the next count
  always_comb begin
    pop_eff  = pop_i & (count_q != '0);
    push_eff = push_i & ((count_q != CW'(DEPTH)) | pop_eff);
    count_d  = count_q;
    case ({push_eff, pop_eff})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // storage, pointers and count; pointers wrap naturally at DEPTH (power of 2)
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_eff) begin
        mem_q[wr_ptr_q] <= din_i;
        wr_ptr_q        <= wr_ptr_q + 1'b1;
      end
      if (pop_eff) rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_d;
    end
  end

  assign dout_o  = mem_q[rd_ptr_q];
  assign valid_o = (count_q != '0);
  assign count_o = count_q;

  // occupancy sanity: no push into a full FIFO without a matching pop
  always @(posedge clk) begin
    if (reset) begin
      assert (!(push_i && (count_q == CW'(DEPTH)) && !pop_eff))
        else $error("rsp fifo overflow");
      assert (count_q <= CW'(DEPTH))
        else $error("rsp fifo count out of range");
    end
  end

endmodule

// File: rtl/sigmoid_share_arbiter.sv
// Round-robin share of one sigmoid unit among N_REQ requesters.
// Registered issue stage drives the unit; a tag pipe tracks the owner of each
// in-flight result; a credit-protected FIFO returns results in issue order.
module sigmoid_share_arbiter
  import act_pkg::*;
#(
  parameter int N_REQ      = N_REQ_DEF,
  parameter int ID_W       = $clog2(N_REQ),
  parameter int UNIT_LAT   = UNIT_LAT_DEF,
  parameter int FIFO_DEPTH = FIFO_DEPTH_DEF
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [N_REQ-1:0]     req_valid,
  input  logic [X_W*N_REQ-1:0] req_x,
  output logic [N_REQ-1:0]     req_ready,
  output logic [X_W-1:0]       act_x,
  output logic                 act_valid,
  input  logic [Y_W-1:0]       act_y,
  output logic                 rsp_valid,
  output logic [Y_W-1:0]       rsp_y,
  output logic [ID_W-1:0]      rsp_id,
  input  logic                 rsp_ready,
  output logic                 busy
);

  localparam int CW    = $clog2(FIFO_DEPTH) + 1;
  localparam int SUM_W = $clog2(FIFO_DEPTH + UNIT_LAT + 2) + 1;
  localparam int EW    = $bits(rsp_entry_t);

  // issue stage
  logic [X_W-1:0]  act_x_q, act_x_d;
  logic            act_valid_q, act_valid_d;
  logic [ID_W-1:0] act_id_q, act_id_d;
  logic [ID_W-1:0] rr_ptr_q, rr_ptr_d;

  // tag pipe, aligned with the unit's internal latency
  logic [UNIT_LAT-1:0]           tag_vld_q;
  logic [UNIT_LAT-1:0][ID_W-1:0] tag_id_q;

  // arbitration / credit
  logic [ID_W-1:0]  cand, gnt_idx;
  logic             gnt_found, gnt_vld, can_issue;
  logic [SUM_W-1:0] inflight, credit_sum;

  // response path
  rsp_entry_t      push_ent, rsp_ent;
  logic [CW-1:0]   fifo_cnt;
  logic [EW-1:0]   fifo_dout;
  logic            fifo_valid;

  // credit count from registered state only, so a pop frees credit next cycle
  always_comb begin
    inflight = SUM_W'(act_valid_q);
    for (int i = 0; i < UNIT_LAT; i++) inflight = inflight + SUM_W'(tag_vld_q[i]);
    credit_sum = inflight + SUM_W'(fifo_cnt);
    can_issue  = credit_sum < SUM_W'(FIFO_DEPTH);
  end

  // round-robin search starting just after the last granted requester
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    cand      = '0;
    for (int k = 1; k <= N_REQ; k++) begin
      cand = ID_W'((int'(rr_ptr_q) + k) % N_REQ);
      if (!gnt_found && req_valid[cand]) begin
        gnt_found = 1'b1;
        gnt_idx   = cand;
      end
    end
    gnt_vld   = can_issue & gnt_found;
    req_ready = gnt_vld ? (N_REQ'(1) << gnt_idx) : '0;
  end

  // next state for issue register and priority pointer
  always_comb begin
    act_valid_d = gnt_vld;
    act_x_d     = act_x_q;
    act_id_d    = act_id_q;
    rr_ptr_d    = rr_ptr_q;
    if (gnt_vld) begin
      act_x_d  = req_x[gnt_idx*X_W +: X_W];
      act_id_d = gnt_idx;
      rr_ptr_d = gnt_idx;
    end
  end

  // issue register; pointer resets to the last index so requester 0 goes first
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      act_x_q     <= '0;
      act_valid_q <= 1'b0;
      act_id_q    <= '0;
      rr_ptr_q    <= ID_W'(N_REQ - 1);
    end else begin
      act_x_q     <= act_x_d;
      act_valid_q <= act_valid_d;
      act_id_q    <= act_id_d;
      rr_ptr_q    <= rr_ptr_d;
    end
  end

  // tag pipe advances every cycle, mirroring the unit's non-stallable pipeline
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tag_vld_q <= '0;
      tag_id_q  <= '0;
    end else begin
      tag_vld_q[0] <= act_valid_q;
      tag_id_q[0]  <= act_id_q;
      for (int i = 1; i < UNIT_LAT; i++) begin
        tag_vld_q[i] <= tag_vld_q[i-1];
        tag_id_q[i]  <= tag_id_q[i-1];
      end
    end
  end

  // pair the unit result with the owner id leaving the tag pipe
  always_comb begin
    push_ent              = '0;
    push_ent.y            = act_y;
    push_ent.id[ID_W-1:0] = tag_id_q[UNIT_LAT-1];
  end

  sigmoid_rsp_fifo #(
    .W     (EW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push_i  (tag_vld_q[UNIT_LAT-1]),
    .din_i   (push_ent),
    .pop_i   (rsp_ready),
    .dout_o  (fifo_dout),
    .valid_o (fifo_valid),
    .count_o (fifo_cnt)
  );

  assign rsp_ent   = rsp_entry_t'(fifo_dout);
  assign rsp_valid = fifo_valid;
  assign rsp_y     = rsp_ent.y;
  assign rsp_id    = rsp_ent.id[ID_W-1:0];
  assign act_x     = act_x_q;
  assign act_valid = act_valid_q;
  assign busy      = act_valid_q | (|tag_vld_q) | fifo_valid;

  // grant shape, bounded in-flight count, and unused id bits stay clear
  always @(posedge clk) begin
    if (reset) begin
      assert ($onehot0(req_ready))
        else $error("req_ready not onehot0");
      assert (inflight <= SUM_W'(UNIT_LAT + 1))
        else $error("too many issues in flight");
      assert ((rsp_ent.id >> ID_W) == '0)
        else $error("response id out of range");
    end
  end

endmodule

// File: tb/tb_sigmoid_share_arbiter.sv
// Directed bench for sigmoid_share_arbiter with a stub unit (y = ~x, 1 cycle).
module tb_sigmoid_share_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  req_valid;
  logic [31:0] req_x;
  logic [3:0]  req_ready;
  logic [7:0]  act_x;
  logic        act_valid;
  logic [7:0]  act_y;
  logic        rsp_valid;
  logic [7:0]  rsp_y;
  logic [1:0]  rsp_id;
  logic        rsp_ready;
  logic        busy;

  int checks = 0;
  int errors = 0;

  sigmoid_share_arbiter #(
    .N_REQ(4), .ID_W(2), .UNIT_LAT(1), .FIFO_DEPTH(4)
  ) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_x(req_x), .req_ready(req_ready),
    .act_x(act_x), .act_valid(act_valid), .act_y(act_y),
    .rsp_valid(rsp_valid), .rsp_y(rsp_y), .rsp_id(rsp_id),
    .rsp_ready(rsp_ready), .busy(busy)
  );

  always #5 clk = ~clk;

  // stub sigmoid unit: one register stage, result is bitwise inverse of x
  always @(posedge clk or negedge reset) begin
    if (!reset) act_y <= 8'h00;
    else        act_y <= ~act_x;
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
      else begin
        errors++;
        $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
      end
  endtask

  initial begin
    logic [1:0] eid;
    logic [7:0] ey;

    // reset state
    reset = 1'b0; req_valid = '0; req_x = '0; rsp_ready = 1'b0;
    tick; tick;
    chk("rst_act_valid", act_valid, 0);
    chk("rst_act_x",     act_x,     0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_y",     rsp_y,     0);
    chk("rst_rsp_id",    rsp_id,    0);
    chk("rst_busy",      busy,      0);
    chk("rst_req_ready", req_ready, 0);
    reset = 1'b1; rsp_ready = 1'b1;

    // single request from lane 2
    req_valid = 4'b0100; req_x = 32'h0010_0000; #1;
    chk("t1_grant", req_ready, 4'b0100);
    tick; req_valid = '0;
    chk("t1_act_valid", act_valid, 1);
    chk("t1_act_x",     act_x,     8'h10);
    chk("t1_rsp_early", rsp_valid, 0);
    tick;
    chk("t1_act_idle", act_valid, 0);
    chk("t1_rsp_wait", rsp_valid, 0);
    chk("t1_busy",     busy,      1);
    tick;
    chk("t1_rsp_valid", rsp_valid, 1);
    chk("t1_rsp_id",    rsp_id,    2);
    chk("t1_rsp_y",     rsp_y,     8'hEF);
    tick;
    chk("t1_drained", busy, 0);

    // all lanes valid, consumer always ready: pointer at 2 so order is 3,0,1,2,...
    req_x = {8'h43, 8'h42, 8'h41, 8'h40}; req_valid = 4'hF;
    for (int k = 0; k < 11; k++) begin
      if (k == 8) req_valid = '0;
      #1;
      if (k < 8) chk("t2_grant", req_ready, 32'd1 << ((3 + k) % 4));
      if (k >= 3) begin
        eid = 2'((3 + k - 3) % 4);
        ey  = 8'hBF - 8'(eid);
        chk("t2_rsp_valid", rsp_valid, 1);
        chk("t2_rsp_id",    rsp_id,    eid);
        chk("t2_rsp_y",     rsp_y,     ey);
      end
      tick;
    end
    chk("t2_drained", busy, 0);

    // consumer stalled: exactly four grants (3,0,1,2) then backpressure
    rsp_ready = 1'b0; req_valid = 4'hF;
    for (int k = 0; k < 8; k++) begin
      #1;
      chk("t3_grant", req_ready, (k < 4) ? (32'd1 << ((3 + k) % 4)) : 32'd0);
      tick;
    end
    chk("t3_full_valid", rsp_valid, 1);
    chk("t3_full_head",  rsp_id,    3);
    chk("t3_full_y",     rsp_y,     8'hBC);
    chk("t3_full_busy",  busy,      1);
    // one-cycle pop: credit returns only on the following cycle
    rsp_ready = 1'b1; #1;
    chk("t3_pop_cycle", req_ready, 0);
    tick; rsp_ready = 1'b0; #1;
    chk("t3_regrant", req_ready, 4'b1000);
    chk("t3_head_id", rsp_id,    0);
    chk("t3_head_y",  rsp_y,     8'hBF);
    tick; #1;
    chk("t3_one_only", req_ready, 0);
    req_valid = '0;

    // push and pop in the same cycle at occupancy 3: order 1,2,3 then empty
    tick; rsp_ready = 1'b1;
    chk("t4_head0", rsp_id, 0);
    tick;
    chk("t4_id1", rsp_id, 1); chk("t4_y1", rsp_y, 8'hBE);
    tick;
    chk("t4_id2", rsp_id, 2); chk("t4_y2", rsp_y, 8'hBD);
    tick;
    chk("t4_id3", rsp_id, 3); chk("t4_y3", rsp_y, 8'hBC);
    chk("t4_v3",  rsp_valid, 1);
    tick;
    chk("t4_empty", rsp_valid, 0);
    chk("t4_idle",  busy,      0);

    // reset in the middle of a burst: 2 in flight, 2 buffered
    rsp_ready = 1'b0; req_valid = 4'hF;
    for (int k = 0; k < 4; k++) begin
      #1;
      chk("t5_grant", req_ready, 32'd1 << k);
      tick;
    end
    #1;
    chk("t5_stalled",   req_ready, 0);
    chk("t5_pre_act",   act_valid, 1);
    chk("t5_pre_rsp",   rsp_valid, 1);
    reset = 1'b0; #1;
    chk("t5_rst_rsp",  rsp_valid, 0);
    chk("t5_rst_act",  act_valid, 0);
    chk("t5_rst_busy", busy,      0);
    tick; reset = 1'b1; #1;
    chk("t5_first_after_rst", req_ready, 4'b0001);
    tick;

    // lane 1 drops out, others served; pointer holds across idle cycles
    rsp_ready = 1'b1; req_valid = 4'b1101;
    #1; chk("t6_g2", req_ready, 4'b0100); tick;
    #1; chk("t6_g3", req_ready, 4'b1000); tick;
    #1; chk("t6_g0", req_ready, 4'b0001); tick;
    req_valid = '0;
    #1; chk("t6_idle", req_ready, 0);
    tick; tick;
    req_valid = 4'hF; #1;
    chk("t6_lane1", req_ready, 4'b0010);
    tick; req_valid = '0;
    repeat (5) tick;
    chk("t6_drained", busy,      0);
    chk("t6_empty",   rsp_valid, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // watchdog
  initial begin
    #20000;
    $display("FAIL watchdog observed timeout expected finish");
    $fatal(1, "timeout");
  end

endmodule
